// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32I core: drives datapath selects,
// write strobes and a request/ready handshake toward the shared memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | decode op, precompute branch/jump target into ALUOut
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access at ALUOut, wait for mem_ready
// EXECR    | R-type ALU operation rs1 op rs2
// EXECI    | I-type ALU operation rs1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, take target held in ALUOut
// JAL      | PC <= target, ALUOut <= OldPC + 4
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= state_t'(RESET_STATE);
    else          state <= state_next;
  end

  // Immediate format follows the opcode regardless of state or reset.
  always_comb begin
    unique case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      // Strobe held for the whole access so the memory may sample it on any wait cycle.
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = zero ^ funct3[0];
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // Datapath stays quiet during reset, including any access left mid-wait.
    if (!reset_n) begin
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors for each
// instruction class, wait states, reset mid-access and an illegal opcode.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b1111111;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {req,pcw,adr,mw,irw,rw,result_src,alu_src_a,alu_src_b,alu_op,imm_src,illegal}
  function automatic logic [16:0] pk(input logic rq, pw, ad, mw, iw, rw,
                                     input logic [1:0] rs, sa, sb, ao, im,
                                     input logic il);
    return {rq, pw, ad, mw, iw, rw, rs, sa, sb, ao, im, il};
  endfunction

  logic [16:0] obs;
  assign obs = {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal};

  // Drive inputs just after a rising edge, check mid-cycle, advance one clock.
  task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic rn,
                     input logic [16:0] expv);
    op = o; funct3 = f3; zero = z; mem_ready = rdy; reset_n = rn;
    #2;
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, expv);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; op = SW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    #1;

    // Reset: everything quiet except imm_src, even with mem_ready high.
    cyc("rst0", SW, 3'b000, 1'b1, 1'b1, 1'b0, pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    cyc("rst1", SW, 3'b000, 1'b1, 1'b1, 1'b0, pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));

    // R-type add, no waits.
    cyc("r_fetch",  RT, 3'b000, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("r_decode", RT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    cyc("r_exec",   RT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0));
    cyc("r_wb",     RT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0));

    // lw: 2 fetch waits, 3 read waits -> 10 cycles.
    cyc("lw_fwait0", LW, 3'b010, 0, 0, 1, pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("lw_fwait1", LW, 3'b010, 0, 0, 1, pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("lw_fetch",  LW, 3'b010, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("lw_decode", LW, 3'b010, 0, 0, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    cyc("lw_memadr", LW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0));
    cyc("lw_rwait0", LW, 3'b010, 0, 0, 1, pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("lw_rwait1", LW, 3'b010, 0, 0, 1, pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("lw_rwait2", LW, 3'b010, 0, 0, 1, pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("lw_read",   LW, 3'b010, 0, 1, 1, pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("lw_wb",     LW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,0));

    // sw with one write wait; mem_ready in DECODE/MEMADR must be ignored.
    cyc("sw_fetch",  SW, 3'b010, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b01,0));
    cyc("sw_decode", SW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0));
    cyc("sw_memadr", SW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0));
    cyc("sw_wwait",  SW, 3'b010, 0, 0, 1, pk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    cyc("sw_write",  SW, 3'b010, 0, 1, 1, pk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));

    // beq zero=1 -> taken.
    cyc("beq1_fetch",  BR, 3'b000, 1, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    cyc("beq1_decode", BR, 3'b000, 1, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    cyc("beq1_branch", BR, 3'b000, 1, 1, 1, pk(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));
    // bne zero=1 -> not taken.
    cyc("bne1_fetch",  BR, 3'b001, 1, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    cyc("bne1_decode", BR, 3'b001, 1, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    cyc("bne1_branch", BR, 3'b001, 1, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));
    // beq zero=0 -> not taken.
    cyc("beq0_fetch",  BR, 3'b000, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    cyc("beq0_decode", BR, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    cyc("beq0_branch", BR, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));
    // bne zero=0 -> taken.
    cyc("bne0_fetch",  BR, 3'b001, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    cyc("bne0_decode", BR, 3'b001, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    cyc("bne0_branch", BR, 3'b001, 0, 1, 1, pk(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));

    // I-type.
    cyc("i_fetch",  IT, 3'b000, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("i_decode", IT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    cyc("i_exec",   IT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0));
    cyc("i_wb",     IT, 3'b000, 0, 1, 1, pk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0));

    // jal.
    cyc("jal_fetch",  JL, 3'b000, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b11,0));
    cyc("jal_decode", JL, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0));
    cyc("jal_jal",    JL, 3'b000, 0, 1, 1, pk(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0));
    cyc("jal_wb",     JL, 3'b000, 0, 1, 1, pk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b11,0));

    // Illegal opcode: pulse in DECODE, then back in FETCH (held by mem_ready=0).
    cyc("ill_fetch",  ILL, 3'b000, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("ill_decode", ILL, 3'b000, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,1));
    cyc("ill_after",  ILL, 3'b000, 0, 0, 1, pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("ill_after2", ILL, 3'b000, 0, 0, 1, pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));

    // Reset in the middle of a load wait.
    cyc("rlw_fetch",  LW, 3'b010, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("rlw_decode", LW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    cyc("rlw_memadr", LW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0));
    cyc("rlw_rwait",  LW, 3'b010, 0, 0, 1, pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("rlw_reset",  LW, 3'b010, 0, 0, 0, pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    cyc("rlw_refetch",LW, 3'b010, 0, 0, 1, pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("rlw_fetch2", LW, 3'b010, 0, 1, 1, pk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    cyc("rlw_decode2",LW, 3'b010, 0, 1, 1, pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction. It drives the datapath mux selects and write strobes and hands `alu_op` to the existing combinational ALU decoder. It adds a request/ready handshake so the shared memory can insert wait states.

## Interface
Parameters:
- `RESET_STATE`, 4'd0 (FETCH): state entered on reset; fixed, not for override in production.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `op`  in  7  opcode `Instr[6:0]` from the instruction register.
- `funct3`  in  3  `Instr[14:12]`; bit 0 selects beq (0) / bne (1).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  store strobe.
- `ir_write`  out  1  instruction register and OldPC enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1 data.
- `alu_src_b`  out  2  00 rs2 data, 01 ImmExt, 10 constant 4.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- `imm_src`  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode.

## Operation
- Eleven states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` assert only in the cycle `mem_ready`=1; the FSM then goes to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch/jump target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - Any other opcode -> FETCH, with `illegal`=1 for this cycle.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next state is MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `adr_src`=1, `mem_write`=1 for every cycle in the state. Holds until `mem_ready`, then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, then ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`.
  - Then FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1, then ALUWB (writes rd = PC+4).
- `imm_src` is combinational from `op` in every state:
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - All other opcodes -> 00.
- Any output not listed for a state is 0.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - The state becomes FETCH on that edge, regardless of the current state, including the middle of a memory wait.
  - While `reset_n`=0, every output except `imm_src` is forced to 0. This includes `mem_req`, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal`.
  - The first `mem_req` appears in the first cycle with `reset_n`=1.
- All outputs are combinational from the state, plus `mem_ready` (FETCH), `zero`/`funct3` (BRANCH) and `op` (DECODE).
- Cycles per instruction with zero wait states:
  - lw 5; sw 4; R-type 4; I-type 4; branch 3; jal 4.
  - Each wait cycle (`mem_req`=1, `mem_ready`=0) adds exactly one cycle.
- Handshake rules:
  - The request stays asserted, with stable `adr_src` and `mem_write`, until `mem_ready`.
  - `mem_ready` outside FETCH, MEMREAD and MEMWRITE is ignored.
- Unsupported opcode costs 2 cycles (FETCH, DECODE). No register or memory write occurs.

## Test plan
- Reset mid-MEMREAD while `mem_ready`=0 -> next cycle in FETCH; `mem_write`=`reg_write`=`pc_write`=0 throughout reset.
- R-type `add` (op 0110011), `mem_ready` tied 1 -> states FETCH, DECODE, EXECR, ALUWB.
  - `reg_write`=1 only in cycle 4; `alu_op`=10 in cycle 3.
- lw with 2 wait cycles in FETCH and 3 in MEMREAD -> 10 cycles total.
  - `ir_write` pulses once, in the ready cycle.
  - `adr_src`=1 throughout MEMREAD.
- sw -> `imm_src`=01; `mem_write`=1 only in MEMWRITE; no `reg_write` cycle.
- beq/bne: beq with `zero`=1, bne with `zero`=1, beq with `zero`=0.
  - `pc_write` in BRANCH = 1, 0, 0 respectively; 3 cycles each.
- op 1111111 -> `illegal`=1 in DECODE; back to FETCH next cycle; no write strobes asserted.
